// File: rtl/multi_ch_disp_scan_pkg.sv
// Shared mode encoding and default constants for the multi-channel display selector.
package disp_pkg;
    typedef enum logic {DISP_MANUAL = 1'b0, DISP_SCAN = 1'b1} disp_mode_e;

    localparam logic [31:0] DISP_RST_DATA = 32'hAA5555AA;
    localparam int          DISP_DIGITS   = 8;
    localparam int          DISP_SCAN_DIV = 25_000_000;
endpackage

// File: rtl/multi_ch_disp_scan_if.sv
// Bundle of control, channel-source and display-side signals of the display selector.
interface multi_ch_disp_scan_if
    import disp_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DW     = 32,
    parameter int DIGITS = DISP_DIGITS
);
    localparam int CW = $clog2(N_CH);

    logic                   en;
    logic                   mode;
    logic                   hold;
    logic [CW-1:0]          sel;
    logic [N_CH*DW-1:0]     data_in;
    logic [N_CH*DIGITS-1:0] point_in;
    logic [N_CH*DIGITS-1:0] blink_in;
    logic [DW-1:0]          disp_num;
    logic [DIGITS-1:0]      point_out;
    logic [DIGITS-1:0]      blink_out;
    logic [CW-1:0]          cur_ch;
    logic                   scan_tick;

    modport master (
        output en, mode, hold, sel, data_in, point_in, blink_in,
        input  disp_num, point_out, blink_out, cur_ch, scan_tick
    );

    modport slave (
        input  en, mode, hold, sel, data_in, point_in, blink_in,
        output disp_num, point_out, blink_out, cur_ch, scan_tick
    );
endinterface

// File: rtl/multi_ch_disp_scan_timer.sv
// Dwell counter for auto-scan: counts 0..SCAN_DIV-1 while running, tick marks the terminal count.
module disp_scan_timer #(
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    input  logic clear,
    output logic tick
);
    localparam int               CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = run && !clear && !hold && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !hold) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multi_ch_disp_scan.sv
// Display-source selector: channel-0 CPU shadow plus pass-through channels, manual select or auto-scan.
// Define DISP_OUT_REG_EN to register disp_num/point_out/blink_out after the channel mux.
module multi_ch_disp_scan
    import disp_pkg::*;
#(
    parameter int            N_CH     = 8,
    parameter int            DW       = 32,
    parameter int            DIGITS   = DISP_DIGITS,
    parameter int            SCAN_DIV = DISP_SCAN_DIV,
    parameter logic [DW-1:0] RST_DATA = DW'(DISP_RST_DATA)
) (
    input logic                 clk,
    input logic                 rst,
    multi_ch_disp_scan_if.slave bus
);
    // state     | meaning
    // ST_MANUAL | cur_ch follows sel, dwell counter held at 0
    // ST_SCAN   | cur_ch advances at each dwell terminal count unless hold
    localparam logic [0:0] ST_MANUAL = DISP_MANUAL;
    localparam logic [0:0] ST_SCAN   = DISP_SCAN;

    localparam int            CW      = $clog2(N_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cur_ch_q, cur_ch_d;
    logic              scan_tick_q, scan_tick_d;
    logic [DW-1:0]     sh_data_q;
    logic [DIGITS-1:0] sh_point_q, sh_blink_q;
    logic [CW-1:0]     sel_ok;
    logic              tmr_run, tmr_tick;
    logic [DW-1:0]     mux_data;
    logic [DIGITS-1:0] mux_point, mux_blink;

    // Leaving SCAN drops the timer immediately, so a tick on that edge never lands.
    assign tmr_run = (state_q == ST_SCAN) && bus.mode;
    assign sel_ok  = (32'(bus.sel) < 32'(N_CH)) ? bus.sel : '0;
    assign state_d = bus.mode ? ST_SCAN : ST_MANUAL;

    disp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (tmr_run),
        .hold  (bus.hold),
        .clear (!tmr_run),
        .tick  (tmr_tick)
    );

    always_comb begin
        cur_ch_d    = cur_ch_q;
        scan_tick_d = 1'b0;
        if (!bus.mode) begin
            cur_ch_d = sel_ok;
        end else if (tmr_tick) begin
            cur_ch_d    = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
            scan_tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_MANUAL;
            cur_ch_q    <= '0;
            scan_tick_q <= 1'b0;
            sh_data_q   <= RST_DATA;
            sh_point_q  <= '0;
            sh_blink_q  <= '1;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            scan_tick_q <= scan_tick_d;
            if (bus.en) begin
                sh_data_q  <= bus.data_in[DW-1:0];
                sh_point_q <= bus.point_in[DIGITS-1:0];
                sh_blink_q <= bus.blink_in[DIGITS-1:0];
            end
        end
    end

    always_comb begin
        if (cur_ch_q == '0) begin
            mux_data  = sh_data_q;
            mux_point = sh_point_q;
            mux_blink = sh_blink_q;
        end else begin
            mux_data  = bus.data_in[int'(cur_ch_q) * DW +: DW];
            mux_point = bus.point_in[int'(cur_ch_q) * DIGITS +: DIGITS];
            mux_blink = bus.blink_in[int'(cur_ch_q) * DIGITS +: DIGITS];
        end
    end

`ifdef DISP_OUT_REG_EN
    logic [DW-1:0]     disp_q;
    logic [DIGITS-1:0] point_q, blink_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= RST_DATA;
            point_q <= '0;
            blink_q <= '1;
        end else begin
            disp_q  <= mux_data;
            point_q <= mux_point;
            blink_q <= mux_blink;
        end
    end

    assign bus.disp_num  = disp_q;
    assign bus.point_out = point_q;
    assign bus.blink_out = blink_q;
`else
    assign bus.disp_num  = mux_data;
    assign bus.point_out = mux_point;
    assign bus.blink_out = mux_blink;
`endif

    assign bus.cur_ch    = cur_ch_q;
    assign bus.scan_tick = scan_tick_q;
endmodule

// File: tb/tb_multi_ch_disp_scan.sv
// Self-checking bench for multi_ch_disp_scan: vector table, corner-case sequences, random run vs. reference model.
module tb_multi_ch_disp_scan;
    localparam int N_CH = 8;
    localparam int DW   = 32;
    localparam int DG   = 8;
    localparam int SDIV = 4;
    localparam int N6   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_ch_disp_scan_if #(.N_CH(N_CH), .DW(DW), .DIGITS(DG)) b ();
    multi_ch_disp_scan_if #(.N_CH(N6),   .DW(DW), .DIGITS(DG)) b6 ();

    multi_ch_disp_scan #(.N_CH(N_CH), .DW(DW), .DIGITS(DG), .SCAN_DIV(SDIV), .RST_DATA(32'hAA5555AA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    multi_ch_disp_scan #(.N_CH(N6), .DW(DW), .DIGITS(DG), .SCAN_DIV(3), .RST_DATA(32'hAA5555AA)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (b6)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: channel index and dwell position as plain integers.
    int          m_cur, m_cnt;
    bit          m_scan, m_tick;
    logic [31:0] m_sh_d, m_o_d;
    logic [7:0]  m_sh_p, m_sh_b, m_o_p, m_o_b;

    function automatic logic [31:0] v_data(int ch);
        return (ch == 0) ? m_sh_d : b.data_in[ch*DW +: DW];
    endfunction
    function automatic logic [7:0] v_point(int ch);
        return (ch == 0) ? m_sh_p : b.point_in[ch*DG +: DG];
    endfunction
    function automatic logic [7:0] v_blink(int ch);
        return (ch == 0) ? m_sh_b : b.blink_in[ch*DG +: DG];
    endfunction

    task automatic model_reset();
        m_sh_d = 32'hAA5555AA; m_sh_p = 8'h00; m_sh_b = 8'hFF;
        m_o_d  = 32'hAA5555AA; m_o_p  = 8'h00; m_o_b  = 8'hFF;
        m_cur = 0; m_cnt = 0; m_scan = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        m_o_d = v_data(m_cur); m_o_p = v_point(m_cur); m_o_b = v_blink(m_cur);
        if (b.en) begin
            m_sh_d = b.data_in[31:0]; m_sh_p = b.point_in[7:0]; m_sh_b = b.blink_in[7:0];
        end
        m_tick = 0;
        if (!b.mode) begin
            m_cur = (int'(b.sel) < N_CH) ? int'(b.sel) : 0;
            m_cnt = 0;
        end else if (!m_scan) begin
            m_cnt = 0;
        end else if (!b.hold) begin
            if (m_cnt == SDIV - 1) begin
                m_cnt  = 0;
                m_cur  = (m_cur + 1) % N_CH;
                m_tick = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_scan = b.mode;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic check_all(input string tag);
`ifdef DISP_OUT_REG_EN
        chk({tag, ".disp"},  b.disp_num,        m_o_d);
        chk({tag, ".point"}, 32'(b.point_out),  32'(m_o_p));
        chk({tag, ".blink"}, 32'(b.blink_out),  32'(m_o_b));
`else
        chk({tag, ".disp"},  b.disp_num,        v_data(m_cur));
        chk({tag, ".point"}, 32'(b.point_out),  32'(v_point(m_cur)));
        chk({tag, ".blink"}, 32'(b.blink_out),  32'(v_blink(m_cur)));
`endif
        chk({tag, ".cur"},   32'(b.cur_ch),     32'(m_cur));
        chk({tag, ".tick"},  32'(b.scan_tick),  32'(m_tick));
    endtask

    task automatic set_data(input logic [31:0] ch0);
        for (int k = 0; k < N_CH; k++) begin
            if (k == 0)      b.data_in[k*DW +: DW] = ch0;
            else if (k == 3) b.data_in[k*DW +: DW] = 32'hDEADBEEF;
            else             b.data_in[k*DW +: DW] = 32'(32'h1000_0000 * k + 32'h1111);
            b.point_in[k*DG +: DG] = (k == 0) ? 8'h0F : 8'(8'h01 << k);
            b.blink_in[k*DG +: DG] = (k == 0) ? 8'hF0 : 8'(~(8'h01 << k));
        end
    endtask

    typedef struct {
        logic        en;
        logic [2:0]  sel;
        logic [31:0] ch0;
        logic [2:0]  e_ch;
        logic [31:0] e_d;
        logic [7:0]  e_p;
        logic [7:0]  e_b;
    } vec_t;

    vec_t tv[7];
    int   tick_cyc[$];
    int   tick_ch[$];
    bit   found;

    initial begin
        tv[0] = '{1'b0, 3'd0, 32'h12345678, 3'd0, 32'hAA5555AA, 8'h00, 8'hFF};
        tv[1] = '{1'b1, 3'd0, 32'h12345678, 3'd0, 32'h12345678, 8'h0F, 8'hF0};
        tv[2] = '{1'b0, 3'd3, 32'h12345678, 3'd3, 32'hDEADBEEF, 8'h08, 8'hF7};
        tv[3] = '{1'b0, 3'd0, 32'hCAFEF00D, 3'd0, 32'h12345678, 8'h0F, 8'hF0};
        tv[4] = '{1'b0, 3'd7, 32'hCAFEF00D, 3'd7, 32'h70001111, 8'h80, 8'h7F};
        tv[5] = '{1'b1, 3'd5, 32'hCAFEF00D, 3'd5, 32'h50001111, 8'h20, 8'hDF};
        tv[6] = '{1'b0, 3'd0, 32'h0BADCAFE, 3'd0, 32'hCAFEF00D, 8'h0F, 8'hF0};

        b.en = 0; b.mode = 0; b.hold = 0; b.sel = '0;
        set_data(32'h12345678);
        b6.en = 0; b6.mode = 0; b6.hold = 0; b6.sel = 3'd0;
        for (int k = 0; k < N6; k++) begin
            b6.data_in[k*DW +: DW]  = 32'(32'hB000_0000 + k);
            b6.point_in[k*DG +: DG] = 8'(k);
            b6.blink_in[k*DG +: DG] = 8'(8'hE0 + k);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Reset state, no en yet
        chk("rst.disp",  b.disp_num,         32'hAA5555AA);
        chk("rst.blink", 32'(b.blink_out),   32'h000000FF);
        chk("rst.point", 32'(b.point_out),   32'h00000000);
        chk("rst.cur",   32'(b.cur_ch),      32'd0);
        chk("rst.tick",  32'(b.scan_tick),   32'd0);

        // Manual-mode vector table; each vector is held two edges so both output builds settle
        for (int i = 0; i < 7; i++) begin
            b.en = tv[i].en; b.sel = tv[i].sel;
            set_data(tv[i].ch0);
            cycle();
            cycle();
            chk($sformatf("tv%0d.cur", i),   32'(b.cur_ch),    32'(tv[i].e_ch));
            chk($sformatf("tv%0d.disp", i),  b.disp_num,       tv[i].e_d);
            chk($sformatf("tv%0d.point", i), 32'(b.point_out), 32'(tv[i].e_p));
            chk($sformatf("tv%0d.blink", i), 32'(b.blink_out), 32'(tv[i].e_b));
        end
        b.en = 0;

        // sel -> cur_ch latency of one edge
        b.sel = 3'd3;
        #1;
        chk("lat.pre.cur", 32'(b.cur_ch), 32'd0);
        cycle();
        chk("lat.cur", 32'(b.cur_ch), 32'd3);
`ifdef DISP_OUT_REG_EN
        chk("lat.disp1", b.disp_num, 32'hCAFEF00D);
`else
        chk("lat.disp1", b.disp_num, 32'hDEADBEEF);
`endif
        cycle();
        chk("lat.disp2", b.disp_num, 32'hDEADBEEF);

        // Six-channel instance: out-of-range sel falls back to channel 0
        b6.sel = 3'd5;
        cycle();
        cycle();
        chk("n6.sel5.cur",  32'(b6.cur_ch), 32'd5);
        chk("n6.sel5.disp", b6.disp_num,    32'hB0000005);
        b6.sel = 3'd7;
        cycle();
        cycle();
        chk("n6.sel7.cur",   32'(b6.cur_ch),    32'd0);
        chk("n6.sel7.disp",  b6.disp_num,       32'hAA5555AA);
        chk("n6.sel7.blink", 32'(b6.blink_out), 32'h000000FF);

        // Auto-scan from channel 6 with a 4-cycle dwell: wraps 7 -> 0 -> 1
        b.sel = 3'd6;
        cycle();
        cycle();
        chk("scan.start.cur", 32'(b.cur_ch), 32'd6);
        b.mode = 1;
        for (int i = 1; i <= 13; i++) begin
            cycle();
            check_all("scan");
            if (b.scan_tick) begin
                tick_cyc.push_back(i);
                tick_ch.push_back(int'(b.cur_ch));
            end
        end
        chk("scan.nticks", 32'(tick_cyc.size()), 32'd3);
        if (tick_cyc.size() == 3) begin
            chk("scan.t0.cyc", 32'(tick_cyc[0]), 32'd5);
            chk("scan.t1.cyc", 32'(tick_cyc[1]), 32'd9);
            chk("scan.t2.cyc", 32'(tick_cyc[2]), 32'd13);
            chk("scan.t0.ch",  32'(tick_ch[0]),  32'd7);
            chk("scan.t1.ch",  32'(tick_ch[1]),  32'd0);
            chk("scan.t2.ch",  32'(tick_ch[2]),  32'd1);
        end

        // hold mid-dwell freezes count and channel, then resumes at the frozen count
        cycle();
        cycle();
        b.hold = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("hold.cur",  32'(b.cur_ch),    32'd1);
            chk("hold.tick", 32'(b.scan_tick), 32'd0);
        end
        b.hold = 0;
        cycle();
        chk("resume1.tick", 32'(b.scan_tick), 32'd0);
        chk("resume1.cur",  32'(b.cur_ch),    32'd1);
        cycle();
        chk("resume2.tick", 32'(b.scan_tick), 32'd1);
        chk("resume2.cur",  32'(b.cur_ch),    32'd2);

        // Run on to channel 5, then pulse reset mid-scan
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            check_all("to5");
            if (b.cur_ch == 3'd5) found = 1;
        end
        chk("reach5", 32'(found), 32'd1);
        #2;
        rst = 1;
        #1;
        model_reset();
        chk("midrst.cur",   32'(b.cur_ch),    32'd0);
        chk("midrst.tick",  32'(b.scan_tick), 32'd0);
        chk("midrst.disp",  b.disp_num,       32'hAA5555AA);
        chk("midrst.point", 32'(b.point_out), 32'h00000000);
        chk("midrst.blink", 32'(b.blink_out), 32'h000000FF);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_all("postrst");
        end

        // Output path relative to cur_ch after a select change
        b.mode = 0;
        b.sel  = 3'd4;
        cycle();
        cycle();
        b.sel = 3'd2;
        cycle();
        chk("olag.cur", 32'(b.cur_ch), 32'd2);
`ifdef DISP_OUT_REG_EN
        chk("olag.disp1", b.disp_num, 32'h40001111);
`else
        chk("olag.disp1", b.disp_num, 32'h20001111);
`endif
        cycle();
        chk("olag.disp2", b.disp_num, 32'h20001111);

        // Randomised run against the reference model
        for (int n = 0; n < 300; n++) begin
            b.en   = ($urandom_range(0, 3) == 0);
            b.hold = ($urandom_range(0, 4) == 0);
            b.sel  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) b.mode = ~b.mode;
            for (int k = 0; k < N_CH; k++) begin
                b.data_in[k*DW +: DW]  = $urandom();
                b.point_in[k*DG +: DG] = 8'($urandom());
                b.blink_in[k*DG +: DG] = 8'($urandom());
            end
            cycle();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
